demux_tree_router: RTL
======================

Name: demux_tree_router

Overview:
Registered 1-to-NUM_OUT demultiplexer with valid/ready handshakes. It is the distribution counterpart to the mux_tree/mux2to1 selection blocks: one input beat is steered to the output lane named by in_sel. Each lane has a one-entry holding register, so a stalled lane never blocks traffic bound for another lane. It sits between a single producer and NUM_OUT independent consumers.

Parameters:
WIDTH, 8, data bits per beat.
NUM_OUT, 4, number of output lanes; legal range 2..16, need not be a power of two.
SEL_W, clog2(NUM_OUT), width of in_sel; derived, not overridden.

Ports:
clk  input  1  rising-edge clock; single clock domain.
rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
in_valid  input  1  input beat present.
in_ready  output  1  router can take the beat this cycle; combinational.
in_sel  input  SEL_W  destination lane index; qualified by in_valid.
in_data  input  WIDTH  beat payload.
out_valid  output  NUM_OUT  per-lane valid, registered.
out_ready  input  NUM_OUT  per-lane consumer ready.
out_data  output  NUM_OUT*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH], registered.
err_pulse  output  1  one-cycle pulse after an out-of-range in_sel beat is dropped.
drop_cnt  output  8  saturating count of dropped beats.

Behaviour:
- Reset (rst_n low at a clk edge):
  - out_valid=0, out_data=0, err_pulse=0, drop_cnt=0.
  - Any held beats are discarded.
  - While rst_n is low, in_ready=0.
- Input acceptance: a beat is accepted when in_valid && in_ready at a clk edge.
- Lane state: each lane k is either EMPTY (out_valid[k]=0) or FULL (out_valid[k]=1). Lane k drains when out_valid[k] && out_ready[k].
- in_ready for a legal sel: in_ready = ~out_valid[in_sel] | out_ready[in_sel].
  - The lane accepts when empty, or when it is draining in the same cycle (pass-through refill, no bubble).
  - in_ready depends combinationally on out_ready. This is the only combinational path.
- in_ready for an illegal sel (in_sel >= NUM_OUT): in_ready=1.
  - The beat is consumed and discarded; no lane changes.
  - err_pulse=1 in the following cycle only.
  - drop_cnt increments by 1 and saturates at 255.
- Latency: a beat accepted at edge t gives out_valid[sel]=1 with out_data lane = in_data after edge t (1 cycle).
- Lane transitions:
  - EMPTY + accept → FULL.
  - FULL + drain, no accept → EMPTY.
  - FULL + drain + accept → FULL with the new data.
  - FULL + no drain → unchanged.
  - A FULL lane holds out_data stable until it drains.
- Data on drain: out_data keeps its last value after a drain (it is not cleared). Verification must check out_data only while out_valid is high.
- Lane independence: lanes are fully independent. A FULL, stalled lane j does not affect in_ready for beats with sel≠j.
- in_sel/in_data while in_ready=0: ignored. The producer must hold them stable while in_valid is high (AXI-style); the router does not check this.
- Simultaneous events: an illegal-sel drop and lane drains in the same cycle are independent and both take effect.
- Saturated counter: a drop arriving while drop_cnt=255 leaves it at 255 and still pulses err_pulse.
- Reset mid-operation: reset overrides every accept and drain in that cycle.

Decomposition:
- Package demux_router_pkg holds:
  - function clog2 (used to derive SEL_W);
  - constant DROP_CNT_W=8;
  - constant DROP_CNT_MAX=8'hFF.
- Sub-module demux_slot, instantiated NUM_OUT times via generate:
  - Ports: clk, rst_n, load, din, out_ready, out_valid, dout, can_load.
  - can_load = ~out_valid | out_ready.
- The top level contains only the sel decode, the in_ready mux, and the error/drop logic.

Test Plan:
1. Reset then single beat: rst_n low 2 cycles, then in_sel=2, in_data=8'hA5, out_ready=4'b1111 → 1 cycle later out_valid=4'b0100 and lane 2 data=8'hA5; out_valid=0 on the next cycle.
2. Stall isolation: out_ready=4'b0000; send sel=1 data 8'h11, then sel=1 data 8'h22 → second beat sees in_ready=0 and lane 1 holds 8'h11. A concurrent sel=3 data 8'h33 is accepted (in_ready=1) and lane 3 shows 8'h33.
3. Pass-through refill: lane 0 FULL with 8'h01, out_ready[0]=1, send sel=0 data 8'h02 in the same cycle → in_ready=1; next cycle out_valid[0]=1 with 8'h02, no bubble.
4. Illegal select: NUM_OUT=3, in_sel=2'd3, data 8'hFF → in_ready=1, no out_valid change, err_pulse=1 for exactly one cycle, drop_cnt=1. Then 300 illegal beats → drop_cnt=255 and err_pulse keeps firing.
5. Reset mid-operation: lanes 0 and 2 FULL, assert rst_n=0 in a cycle that also has a legal accept → out_valid=0, out_data=0, drop_cnt=0 after that edge; in_ready=0 while reset is held.
6. Random back-to-back: 1000 beats with random sel and random out_ready → a scoreboard confirms per-lane in-order delivery, no loss or duplication, and 1-cycle minimum latency.

Source files
------------

// File: rtl/demux_router_pkg.sv
// Shared definitions for the demux tree router.
//   clog2        : ceiling log2, used to size the lane-select field.
//   DROP_CNT_W   : width of the dropped-beat counter.
//   DROP_CNT_MAX : saturation value of the dropped-beat counter.
package demux_router_pkg;

    localparam int DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'hFF;

    // Smallest r with 2**r >= n. It is only evaluated at elaboration time.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output lane of the router.
//   clk, rst_n  : clock and synchronous active-low reset.
//   load        : capture din this cycle. The parent only raises it when can_load is high.
//   din         : beat payload to capture.
//   out_ready   : consumer ready. The lane drains when out_valid && out_ready.
//   out_valid   : lane holds a beat (FULL).
//   dout        : held payload. It keeps its last value after a drain.
//   can_load    : the lane can take a beat this cycle, either because it is empty or because it is draining now.
module demux_slot
    import demux_router_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] dout,
    output logic             can_load
);

    // Pass-through refill: a lane that drains this cycle can take a new beat in the same cycle.
    assign can_load = ~out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            dout      <= din;
        end else if (out_ready) begin
            // Only the valid bit is cleared on a drain. dout keeps its value.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_tree_router.sv
// Registered 1-to-NUM_OUT demultiplexer with valid/ready handshakes.
// Each input beat goes to lane in_sel. Every lane has a one-entry holding slot,
// so a stalled lane only back-pressures beats that are addressed to it.
//   clk, rst_n          : clock and synchronous active-low reset.
//   in_valid/in_ready   : producer handshake. in_ready is combinational from out_ready.
//   in_sel, in_data     : destination lane and payload.
//   out_valid/out_ready : per-lane consumer handshakes.
//   out_data            : lane k occupies bits [k*WIDTH +: WIDTH].
//   err_pulse           : one-cycle pulse after a beat with out-of-range in_sel is dropped.
//   drop_cnt            : saturating count of dropped beats.
module demux_tree_router
    import demux_router_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int NUM_OUT = 4,
    localparam int SEL_W   = clog2(NUM_OUT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic [WIDTH-1:0]         in_data,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic [NUM_OUT*WIDTH-1:0] out_data,
    output logic                     err_pulse,
    output logic [DROP_CNT_W-1:0]    drop_cnt
);

    // Number of codes in_sel can carry. Codes from NUM_OUT upward are illegal.
    localparam int NUM_SEL = 1 << SEL_W;

    logic [NUM_OUT-1:0] can_load;
    logic [NUM_OUT-1:0] load;
    logic [NUM_SEL-1:0] sel_ready;
    logic               sel_legal;
    logic               accept;
    logic               drop;

    assign sel_legal = (int'(in_sel) < NUM_OUT);

    // Illegal codes are padded with ready=1. Those beats are always taken and then discarded.
    always_comb begin
        sel_ready                = '1;
        sel_ready[NUM_OUT-1:0]   = can_load;
    end

    assign in_ready = rst_n & sel_ready[in_sel];
    assign accept   = in_valid & in_ready;
    assign drop     = accept & ~sel_legal;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
        assign load[k] = accept & (int'(in_sel) == k);

        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .din       (in_data),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .dout      (out_data[k*WIDTH +: WIDTH]),
            .can_load  (can_load[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_pulse <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            err_pulse <= drop;
            // The counter stops at its maximum. err_pulse still fires for each drop.
            if (drop && drop_cnt != DROP_CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule
